// File: rtl/reg_file_mp.sv
// reg_file_mp
//   Multi-port integer register file with a per-register busy scoreboard.
//   Serves NUM_RD combinational source-operand reads and NUM_WR writebacks
//   per cycle. Tracks outstanding destination reservations so that issue can
//   detect RAW hazards. Register x0 reads as zero, is never busy, and ignores
//   writes and reservations.
//
//   Optional feature macro: REG_FILE_BYPASS_EN
//     defined   : a read of a register being written this cycle returns the
//                 write data and sees the busy bit already cleared
//     undefined : reads return stored state only
//
// Parameters
//   XLEN       data width
//   ADDR_WIDTH register address width, depth = 2**ADDR_WIDTH
//   NUM_RD     read ports (1..4)
//   NUM_WR     write ports (1..2)
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   rs_addr   in   read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rs_data   out  read data, port i at [i*XLEN +: XLEN]
//   rs_busy   out  per read port: addressed register has a reservation
//   rd_web    in   per write port write enable, active-low
//   rd_addr   in   write addresses
//   rd_data   in   write data
//   rsv_en    in   reservation request
//   rsv_addr  in   register to reserve
//   rsv_ok    out  reservation accepted this cycle
module reg_file_mp #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rs_addr,
  output logic [NUM_RD*XLEN-1:0]       rs_data,
  output logic [NUM_RD-1:0]            rs_busy,
  input  logic [NUM_WR-1:0]            rd_web,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] rd_addr,
  input  logic [NUM_WR*XLEN-1:0]       rd_data,
  input  logic                         rsv_en,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr,
  output logic                         rsv_ok
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [XLEN-1:0]       regs_q [DEPTH];
  logic [XLEN-1:0]       regs_d [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;

  logic [ADDR_WIDTH-1:0] ra     [NUM_RD];
  logic [ADDR_WIDTH-1:0] wa     [NUM_WR];
  logic [XLEN-1:0]       wd     [NUM_WR];
  logic [NUM_WR-1:0]     we;
  logic                  rsv_accept;
  logic [XLEN-1:0]       rd_val [NUM_RD];
  logic [NUM_RD-1:0]     rd_bsy;

  // Unpack the flat port buses; writes to x0 are dropped here once.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      ra[i] = rs_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
    for (int j = 0; j < NUM_WR; j++) begin
      wa[j] = rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
      wd[j] = rd_data[j*XLEN +: XLEN];
      we[j] = ~rd_web[j] && (wa[j] != '0);
    end
  end

  // busy_q[0] is never set, so x0 always accepts. rsv_ok deliberately sees
  // only the stored busy bit: no path from rs_addr or the write ports.
  always_comb begin
    rsv_ok     = rsv_en & ~busy_q[rsv_addr];
    rsv_accept = rsv_ok && (rsv_addr != '0);
  end

  // Next state: writes in ascending port order so the highest-index port wins
  // a collision; the reservation is applied last so a new producer reserving
  // the register being written leaves it busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (we[j]) begin
        regs_d[wa[j]] = wd[j];
        busy_d[wa[j]] = 1'b0;
      end
    end
    if (rsv_accept) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read ports: independent, aliasing allowed, x0 forced to zero / not busy.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_val[i] = regs_q[ra[i]];
      rd_bsy[i] = busy_q[ra[i]];
`ifdef REG_FILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && (wa[j] == ra[i])) begin
          rd_val[i] = wd[j];
          // A same-cycle accepted reservation keeps the pre-edge busy view.
          rd_bsy[i] = (rsv_accept && (rsv_addr == ra[i])) ? busy_q[ra[i]] : 1'b0;
        end
      end
`endif
      if (ra[i] == '0) begin
        rd_val[i] = '0;
        rd_bsy[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rs_data[i*XLEN +: XLEN] = rd_val[i];
      rs_busy[i]              = rd_bsy[i];
    end
  end

endmodule
